// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES encryption round scheduler.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int NR_MAX      = 14;
  localparam int KS_MAX_W    = (NR_MAX + 1) * AES_BLOCK_W;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    HOLD
  } sched_state_t;

  function automatic int nr_for_nk(input int nk);
    return nk + 6;
  endfunction

  // Round 0 sits in the MSBs of the schedule, so later rounds walk down.
  function automatic logic [AES_BLOCK_W-1:0] round_key(input logic [KS_MAX_W-1:0] w,
                                                       input int nr,
                                                       input int r);
    return w[(nr - r) * AES_BLOCK_W +: AES_BLOCK_W];
  endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Two-input round-robin arbiter; the pointer favours the requester that lost last time.
module aes_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_valid,
  input  logic       i_enable,
  input  logic       i_advance,
  output logic [1:0] o_grant,
  output logic       o_grant_idx
);

  logic r_rr_ptr;

  always_comb begin
    o_grant_idx = 1'b0;
    case (i_valid)
      2'b10:   o_grant_idx = 1'b1;
      2'b11:   o_grant_idx = r_rr_ptr;
      default: o_grant_idx = 1'b0;
    endcase
    o_grant = i_enable ? (i_valid & (o_grant_idx ? 2'b10 : 2'b01)) : 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_rr_ptr <= 1'b0;
    else if (i_advance) r_rr_ptr <= ~o_grant_idx;
  end

endmodule

// File: rtl/aes_enc_scheduler.sv
// Shares one external iterative AES round datapath between two requesters.
//   state | meaning
//   IDLE  | arbitrate and accept a plaintext, add round-0 key
//   ROUND | drive datapath one round per cycle, capture final round into output
//   HOLD  | ciphertext presented until the consumer takes it
module aes_enc_scheduler
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [(NR+1)*AES_BLOCK_W-1:0] w,
  input  logic                         req0_valid,
  input  logic [AES_BLOCK_W-1:0]       req0_data,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [AES_BLOCK_W-1:0]       req1_data,
  output logic                         req1_ready,
  output logic                         out_valid,
  output logic [AES_BLOCK_W-1:0]       out_data,
  output logic                         out_id,
  input  logic                         out_ready,
  output logic [AES_BLOCK_W-1:0]       dp_state,
  output logic [AES_BLOCK_W-1:0]       dp_key,
  output logic                         dp_last,
  input  logic [AES_BLOCK_W-1:0]       dp_result,
  output logic                         busy
);

  localparam int CNT_W = $clog2(NR + 1);

  if (NR != nr_for_nk(NK) || !(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_cfg
    $error("aes_enc_scheduler: NK must be 4/6/8 and NR must equal NK+6");
  end

  sched_state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_round_cnt;
  logic [AES_BLOCK_W-1:0]  r_state_reg;
  logic                    r_id;
  logic                    r_out_valid;
  logic [AES_BLOCK_W-1:0]  r_out_data;
  logic                    r_out_id;

  logic [1:0]              w_grant;
  logic                    w_grant_idx;
  logic                    w_enable;
  logic                    w_accept;
  logic                    w_step;
  logic                    w_finish;
  logic                    w_release;
  logic                    w_in_round;
  logic [KS_MAX_W-1:0]     w_ks_ext;
  logic [AES_BLOCK_W-1:0]  w_key0;
  logic [AES_BLOCK_W-1:0]  w_key_cur;
  logic [AES_BLOCK_W-1:0]  w_plain;

  // Ready is gated by reset too, so nothing looks accepted while reset is held.
  assign w_enable = (r_state == IDLE) && !reset;
  assign w_accept = |w_grant;

  aes_rr_arbiter u_arb (
    .clk         (clk),
    .reset       (reset),
    .i_valid     ({req1_valid, req0_valid}),
    .i_enable    (w_enable),
    .i_advance   (w_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign w_ks_ext  = KS_MAX_W'(w);
  assign w_key0    = round_key(w_ks_ext, NR, 0);
  assign w_key_cur = round_key(w_ks_ext, NR, int'(r_round_cnt));
  assign w_plain   = w_grant_idx ? req1_data : req0_data;

  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = ROUND;
      end
      ROUND: begin
        if (r_round_cnt == CNT_W'(NR)) begin
          w_finish    = 1'b1;
          w_state_nxt = HOLD;
        end else begin
          w_step = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_release   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_round_cnt <= '0;
      r_state_reg <= '0;
      r_id        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_state_reg <= w_plain ^ w_key0;
        r_id        <= w_grant_idx;
        r_round_cnt <= CNT_W'(1);
      end else if (w_step) begin
        r_state_reg <= dp_result;
        r_round_cnt <= r_round_cnt + CNT_W'(1);
      end
      if (w_finish) begin
        r_out_data  <= dp_result;
        r_out_id    <= r_id;
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign w_in_round = (r_state == ROUND);
  assign dp_state   = w_in_round ? r_state_reg : '0;
  assign dp_key     = w_in_round ? w_key_cur : '0;
  assign dp_last    = w_in_round && (r_round_cnt == CNT_W'(NR));

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_id     = r_out_id;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_aes_enc_scheduler.sv
// Scoreboard bench: models the external round datapath and checks ciphertexts against a full AES model.
module tb_aes_enc_scheduler;

  localparam int NR  = 10;
  localparam int NRB = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset;
  logic [(NR+1)*128-1:0]   w;
  logic                    req0_valid, req1_valid, req0_ready, req1_ready;
  logic [127:0]            req0_data, req1_data;
  logic                    out_valid, out_id, out_ready, dp_last, busy;
  logic [127:0]            out_data, dp_state, dp_key, dp_result;

  logic [(NRB+1)*128-1:0]  wb;
  logic                    b0_valid, b1_valid, b0_ready, b1_ready;
  logic [127:0]            b0_data, b1_data;
  logic                    b_ovalid, b_oid, b_oready, b_dplast, b_busy;
  logic [127:0]            b_odata, b_dpstate, b_dpkey, b_dpresult;

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box from its definition: inverse in GF(2^8) (x^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] e;
    inv = 8'h01; e = 8'd254;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (e[i]) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
        t[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  // Key words left-aligned in a 256-bit value; schedule returned with round 0 in the MSBs.
  function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk);
    logic [31:0] wd [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [1919:0] flat;
    int nr;
    nr = nk + 6; rc = 8'h01; flat = '0;
    for (int i = 0; i < 60; i++) wd[i] = 32'h0;
    for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = wd[i-1];
      if (i % nk == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      wd[i] = wd[i-nk] ^ tmp;
    end
    for (int i = 0; i < 4*(nr+1); i++) flat[1919-32*i -: 32] = wd[i];
    return flat;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [255:0] key,
                                               input int nk);
    logic [1919:0] ks;
    logic [127:0] s;
    int nr;
    nr = nk + 6;
    ks = expand_key(key, nk);
    s  = pt ^ ks[1919 -: 128];
    for (int r = 1; r <= nr; r++) s = aes_round(s, ks[1919-128*r -: 128], r == nr);
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // External datapaths modelled combinationally.
  assign dp_result  = aes_round(dp_state, dp_key, dp_last);
  assign b_dpresult = aes_round(b_dpstate, b_dpkey, b_dplast);

  aes_enc_scheduler #(.NK(4), .NR(NR)) u_dut (
    .clk(clk), .reset(reset), .w(w),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
    .dp_state(dp_state), .dp_key(dp_key), .dp_last(dp_last), .dp_result(dp_result),
    .busy(busy)
  );

  aes_enc_scheduler #(.NK(8), .NR(NRB)) u_dut256 (
    .clk(clk), .reset(reset), .w(wb),
    .req0_valid(b0_valid), .req0_data(b0_data), .req0_ready(b0_ready),
    .req1_valid(b1_valid), .req1_data(b1_data), .req1_ready(b1_ready),
    .out_valid(b_ovalid), .out_data(b_odata), .out_id(b_oid), .out_ready(b_oready),
    .dp_state(b_dpstate), .dp_key(b_dpkey), .dp_last(b_dplast), .dp_result(b_dpresult),
    .busy(b_busy)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic         id;
    logic [127:0] data;
  } exp_t;

  exp_t         exp_q[$];
  int           acc_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           n_out = 0;
  int           last_acc_edge = -1;
  int           last_hs_edge = -1;
  logic [127:0] last_out_data = '0;
  logic         last_out_id = 1'b0;
  logic [255:0] cur_key = '0;
  bit           chk_alt = 1'b0;
  bit           chk_space = 1'b0;
  logic         exp_next_id = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timed_out(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    logic         prev_ov, prev_or, prev_oid, id;
    logic [127:0] prev_od;
    exp_t         e;
    prev_ov = 1'b0; prev_or = 1'b0; prev_oid = 1'b0; prev_od = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        acc_q.delete();
        prev_ov = 1'b0;
        prev_or = 1'b0;
      end else begin
        check("dual_ready", 128'(req0_ready & req1_ready), 128'(0));
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          id = req1_valid && req1_ready;
          exp_q.push_back({id, aes_encrypt(id ? req1_data : req0_data, cur_key, 4)});
          acc_q.push_back(cyc + 1);
          if (chk_space && last_acc_edge >= 0)
            check("accept_spacing", 128'(cyc + 1 - last_acc_edge), 128'(NR + 2));
          if (chk_alt) begin
            check("grant_order", 128'(id), 128'(exp_next_id));
            exp_next_id = !id;
          end
          last_acc_edge = cyc + 1;
        end
        if (out_valid && !prev_ov) begin
          if (acc_q.size() == 0) timed_out("unexpected_out_valid");
          else check("latency", 128'(cyc - acc_q.pop_front()), 128'(NR));
        end
        if (prev_ov && !prev_or) begin
          check("hold_valid", 128'(out_valid), 128'(1));
          check("hold_data", out_data, prev_od);
          check("hold_id", 128'(out_id), 128'(prev_oid));
          check("hold_ready", 128'({req1_ready, req0_ready}), 128'(0));
          check("hold_busy", 128'(busy), 128'(1));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            timed_out("unexpected_output");
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_id", 128'(out_id), 128'(e.id));
          end
          n_out++;
          last_hs_edge  = cyc + 1;
          last_out_data = out_data;
          last_out_id   = out_id;
        end
        prev_ov = out_valid; prev_or = out_ready; prev_od = out_data; prev_oid = out_id;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_key(input logic [127:0] k);
    logic [1919:0] ks;
    cur_key = {k, 128'h0};
    ks = expand_key(cur_key, 4);
    w = ks[1919 -: (NR+1)*128];
  endtask

  task automatic send(input int id, input logic [127:0] pt, input bit keep);
    bit got;
    int n;
    got = 1'b0; n = 0;
    if (id == 1) begin req1_data = pt; req1_valid = 1'b1; end
    else         begin req0_data = pt; req0_valid = 1'b1; end
    while (!got && n < 300) begin
      @(negedge clk);
      got = (id == 1) ? req1_ready : req0_ready;
      n++;
    end
    if (!got) timed_out("accept_wait");
    @(posedge clk); #1;
    if (!keep) begin
      if (id == 1) req1_valid = 1'b0;
      else         req0_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) timed_out("drain");
    @(posedge clk); #1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [127:0] c0 [4];
    logic [127:0] c1 [4];
    logic [127:0] pend;
    logic [1919:0] ksb;
    bit  rdone;
    int  n, acc_b, outs_before;
    bit  got;

    reset = 1'b1; out_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    b0_valid = 1'b0; b1_valid = 1'b0; b0_data = '0; b1_data = '0; b_oready = 1'b1; wb = '0;
    set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    for (int i = 0; i < 4; i++) begin c0[i] = rand128(); c1[i] = rand128(); end
    req0_data = c0[0]; req1_data = c1[0]; req0_valid = 1'b1; req1_valid = 1'b1;
    gap(3);

    check("rst_ready0", 128'(req0_ready), 128'(0));
    check("rst_ready1", 128'(req1_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    check("rst_out_id", 128'(out_id), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_dp_state", dp_state, 128'(0));
    check("rst_dp_key", dp_key, 128'(0));
    check("rst_dp_last", 128'(dp_last), 128'(0));
    check("rst_busy_256", 128'(b_busy), 128'(0));

    // Contention: both valid from reset, alternating grants 12 cycles apart.
    chk_alt = 1'b1; exp_next_id = 1'b0; chk_space = 1'b1; last_acc_edge = -1;
    reset = 1'b0;
    fork
      for (int i = 0; i < 4; i++) send(0, c0[i], i < 3);
      for (int i = 0; i < 4; i++) send(1, c1[i], i < 3);
    join
    drain();
    chk_alt = 1'b0; chk_space = 1'b0;

    // FIPS-197 Appendix B through requester 0.
    send(0, 128'h3243f6a8885a308d313198a2e0370734, 1'b0);
    drain();
    check("fips_b_data", last_out_data, 128'h3925841d02dc09fbdc118597196a0b32);
    check("fips_b_id", 128'(last_out_id), 128'(0));

    // FIPS-197 Appendix C.1 through requester 1.
    set_key(128'h000102030405060708090a0b0c0d0e0f);
    send(1, 128'h00112233445566778899aabbccddeeff, 1'b0);
    drain();
    check("fips_c1_data", last_out_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("fips_c1_id", 128'(last_out_id), 128'(1));

    // Backpressure: hold output 20 cycles with another block waiting.
    out_ready = 1'b0;
    send(0, rand128(), 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) timed_out("bp_out_valid");
    pend = rand128();
    @(posedge clk); #1;
    req1_data = pend; req1_valid = 1'b1;
    gap(20);
    check("bp_busy", 128'(busy), 128'(1));
    check("bp_ready1", 128'(req1_ready), 128'(0));
    outs_before = n_out;
    out_ready = 1'b1;
    send(1, pend, 1'b0);
    check("bp_one_handshake", 128'(n_out - outs_before), 128'(1));
    check("bp_resume_gap", 128'(last_acc_edge - last_hs_edge), 128'(1));
    drain();

    // Randomized traffic with random backpressure.
    set_key(rand128());
    rdone = 1'b0;
    fork
      begin
        fork
          for (int i = 0; i < 6; i++) begin send(0, rand128(), 1'b0); gap($urandom_range(0, 3)); end
          for (int i = 0; i < 6; i++) begin send(1, rand128(), 1'b0); gap($urandom_range(0, 3)); end
        join
        rdone = 1'b1;
      end
      while (!rdone) begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 2) != 0);
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset in the middle of a block; rr pointer was left at 1 by this accept.
    send(0, rand128(), 1'b0);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_out_data", out_data, 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_dp_state", dp_state, 128'(0));
    check("mid_rst_dp_key", dp_key, 128'(0));
    check("mid_rst_dp_last", 128'(dp_last), 128'(0));
    gap(2);
    reset = 1'b0;
    outs_before = n_out;
    gap(20);
    check("mid_rst_no_output", 128'(n_out - outs_before), 128'(0));
    chk_alt = 1'b1; exp_next_id = 1'b0;
    fork
      send(0, rand128(), 1'b0);
      send(1, rand128(), 1'b0);
    join
    drain();
    chk_alt = 1'b0;

    // AES-256 instance, FIPS-197 Appendix C.3.
    ksb = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
    wb = ksb;
    b0_data = 128'h00112233445566778899aabbccddeeff; b0_valid = 1'b1;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin @(negedge clk); got = b0_ready; n++; end
    if (!got) timed_out("aes256_accept");
    acc_b = cyc + 1;
    @(posedge clk); #1;
    b0_valid = 1'b0;
    n = 0;
    while (!b_ovalid && n < 40) begin
      @(negedge clk);
      check("aes256_ready1", 128'(b1_ready), 128'(0));
      n++;
    end
    if (!b_ovalid) timed_out("aes256_out_valid");
    check("aes256_latency", 128'(cyc - acc_b), 128'(NRB));
    check("aes256_data", b_odata, 128'h8ea2b7ca516745bfeafc49904b496089);
    check("aes256_id", 128'(b_oid), 128'(0));
    gap(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
